// File: rtl/pending_priority_encoder_pkg.sv
// Shared definitions for the pending-request priority encoder:
// selection modes, FSM state encoding and index-width helper.
package pending_priority_encoder_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pending_priority_encoder_checker.sv
// Handshake and range properties of the encoder's grant output.
module pending_priority_encoder_checker #(
    parameter int N = 8,
    parameter int W = 3
) (
    input logic         clk,
    input logic         resetn,
    input logic         out_valid,
    input logic [W-1:0] out_idx,
    input logic         out_ack
);

    a_idx_range : assert property (@(posedge clk) disable iff (!resetn)
        out_valid |-> (int'(out_idx) < N));

    a_gap_after_ack : assert property (@(posedge clk) disable iff (!resetn)
        (out_valid && out_ack) |=> !out_valid);

    a_hold_stable : assert property (@(posedge clk) disable iff (!resetn)
        (out_valid && !out_ack) |=> (out_valid && $stable(out_idx)));

endmodule

// File: rtl/pending_priority_encoder_prio_select.sv
// Combinational winner selection over the eligible vector, either
// highest-index-wins or round-robin descending from rr_ptr.
module pending_priority_encoder_prio_select
    import pending_priority_encoder_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = MODE_FIXED,
    parameter int W  = idx_width(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] sel_idx,
    output logic         sel_any
);

    logic [W-1:0] hi_idx_s;
    logic         hi_any_s;
    logic [W-1:0] lo_idx_s;
    logic         lo_any_s;
    logic         lo_hit_s;

    // Round-robin = highest eligible index below rr_ptr, else highest overall;
    // this walks rr_ptr-1 down to 0 and wraps to N-1 without modulo arithmetic.
    always_comb begin
        hi_idx_s = '0;
        hi_any_s = 1'b0;
        lo_idx_s = '0;
        lo_any_s = 1'b0;
        lo_hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            lo_hit_s = elig[i] && (RR == MODE_RR) && (i < int'(rr_ptr));
            hi_idx_s = elig[i] ? W'(i) : hi_idx_s;
            hi_any_s = hi_any_s | elig[i];
            lo_idx_s = lo_hit_s ? W'(i) : lo_idx_s;
            lo_any_s = lo_any_s | lo_hit_s;
        end
        sel_idx = lo_any_s ? lo_idx_s : hi_idx_s;
        sel_any = hi_any_s;
    end

endmodule

// File: rtl/pending_priority_encoder.sv
// Sticky, maskable request register feeding a one-at-a-time valid/ack
// grant port with fixed-priority or round-robin selection.
module pending_priority_encoder
    import pending_priority_encoder_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int RR = MODE_FIXED,
    localparam int W  = idx_width(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    input  logic         mask_we,
    input  logic [N-1:0] mask_in,
    input  logic         out_ack,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         any_pending
);

    logic [N-1:0] pending_q,     pending_d;
    logic [N-1:0] mask_q,        mask_d;
    logic         out_valid_q,   out_valid_d;
    logic [W-1:0] out_idx_q,     out_idx_d;
    logic         any_pending_q, any_pending_d;
    logic [W-1:0] rr_ptr_q,      rr_ptr_d;
    state_e       state_q,       state_d;

    logic         ack_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] elig_s;
    logic [W-1:0] sel_idx_s;
    logic         sel_any_s;

    // Pending/mask next state; a same-cycle request wins over the ack clear.
    always_comb begin
        ack_s = out_valid_q & out_ack;
        clr_s = '0;
        for (int i = 0; i < N; i++) begin
            clr_s[i] = ack_s & (out_idx_q == W'(i));
        end
        pending_d     = (pending_q & ~clr_s) | req;
        elig_s        = (pending_q | req) & ~mask_q;
        mask_d        = mask_we ? mask_in : mask_q;
        any_pending_d = |pending_d;
    end

    pending_priority_encoder_prio_select #(
        .N  (N),
        .RR (RR),
        .W  (W)
    ) u_sel (
        .elig    (elig_s),
        .rr_ptr  (rr_ptr_q),
        .sel_idx (sel_idx_s),
        .sel_any (sel_any_s)
    );

    // Grant FSM: capture a winner in IDLE, hold it unchanged until acknowledged.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any_s) begin
                    out_idx_d   = sel_idx_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ack) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    rr_ptr_d    = (RR == MODE_RR) ? out_idx_q : rr_ptr_q;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q     <= '0;
            mask_q        <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= '0;
            any_pending_q <= 1'b0;
            rr_ptr_q      <= '0;
            state_q       <= ST_IDLE;
        end else begin
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            any_pending_q <= any_pending_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign any_pending = any_pending_q;

    pending_priority_encoder_checker #(
        .N (N),
        .W (W)
    ) u_chk (
        .clk       (clk),
        .resetn    (resetn),
        .out_valid (out_valid_q),
        .out_idx   (out_idx_q),
        .out_ack   (out_ack)
    );

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Bench for pending_priority_encoder: fixed N=8, round-robin N=8 and N=5
// instances driven with shared stimulus and compared against a reference model.
module tb_pending_priority_encoder;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       out_ack;

    logic       v_f,  ap_f;   logic [2:0] idx_f;
    logic       v_r8, ap_r8;  logic [2:0] idx_r8;
    logic       v_r5, ap_r5;  logic [2:0] idx_r5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pending_priority_encoder #(.N(8), .RR(0)) dut_f (
        .clk(clk), .resetn(resetn), .req(req), .mask_we(mask_we), .mask_in(mask_in),
        .out_ack(out_ack), .out_valid(v_f), .out_idx(idx_f), .any_pending(ap_f));

    pending_priority_encoder #(.N(8), .RR(1)) dut_r8 (
        .clk(clk), .resetn(resetn), .req(req), .mask_we(mask_we), .mask_in(mask_in),
        .out_ack(out_ack), .out_valid(v_r8), .out_idx(idx_r8), .any_pending(ap_r8));

    pending_priority_encoder #(.N(5), .RR(1)) dut_r5 (
        .clk(clk), .resetn(resetn), .req(req[4:0]), .mask_we(mask_we), .mask_in(mask_in[4:0]),
        .out_ack(out_ack), .out_valid(v_r5), .out_idx(idx_r5), .any_pending(ap_r5));

    // Reference model state, one slot per instance: 0 fixed/8, 1 rr/8, 2 rr/5.
    int         n_of [3] = '{8, 8, 5};
    int         rr_of[3] = '{0, 1, 1};
    logic [7:0] m_pend[3];
    logic [7:0] m_mask[3];
    bit         m_valid[3];
    int         m_idx[3];
    int         m_ptr[3];
    bit         m_anyp[3];

    typedef struct {
        logic [7:0] req;
        logic       mwe;
        logic [7:0] min;
        logic       ack;
        logic       ev;
        logic [2:0] eidx;
        logic       eap;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [7:0] r, input logic we, input logic [7:0] mi,
                                input logic a, input logic ev, input logic [2:0] ei,
                                input logic eap);
        vec_t v;
        v.req = r; v.mwe = we; v.min = mi; v.ack = a; v.ev = ev; v.eidx = ei; v.eap = eap;
        return v;
    endfunction

    // Search order from the rules: fixed = highest index; rr = ptr-1, ptr-2, ... mod n.
    function automatic int pick(input logic [7:0] e, input int n, input int rr, input int ptr);
        if (rr == 0) begin
            for (int i = n - 1; i >= 0; i--) if (e[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (((ptr - k) % n) + n) % n;
                if (e[c]) return c;
            end
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 8'h00; m_mask[k] = 8'h00; m_valid[k] = 1'b0;
            m_idx[k] = 0; m_ptr[k] = 0; m_anyp[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] lim, r, e, clr, np;
            lim = (k == 2) ? 8'h1F : 8'hFF;
            r   = req & lim;
            e   = (m_pend[k] | r) & ~m_mask[k] & lim;
            clr = 8'h00;
            if (m_valid[k] && out_ack) clr[m_idx[k]] = 1'b1;
            np  = (m_pend[k] & ~clr) | r;
            if (!m_valid[k]) begin
                if (e != 8'h00) begin
                    m_idx[k]   = pick(e, n_of[k], rr_of[k], m_ptr[k]);
                    m_valid[k] = 1'b1;
                end
            end else if (out_ack) begin
                m_valid[k] = 1'b0;
                if (rr_of[k] != 0) m_ptr[k] = m_idx[k];
            end
            if (mask_we) m_mask[k] = mask_in & lim;
            m_pend[k] = np;
            m_anyp[k] = (np != 8'h00);
        end
    endtask

    task automatic check_model(input string tag);
        logic dv[3]; logic [2:0] di[3]; logic da[3];
        dv[0] = v_f;  di[0] = idx_f;  da[0] = ap_f;
        dv[1] = v_r8; di[1] = idx_r8; da[1] = ap_r8;
        dv[2] = v_r5; di[2] = idx_r5; da[2] = ap_r5;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_valid_u%0d", tag, k), int'(dv[k]), int'(m_valid[k]));
            chk($sformatf("%s_anyp_u%0d", tag, k), int'(da[k]), int'(m_anyp[k]));
            if (m_valid[k]) chk($sformatf("%s_idx_u%0d", tag, k), int'(di[k]), m_idx[k]);
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    int q8[$];
    int q5[$];
    int exp8[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int exp5[6] = '{4, 3, 2, 1, 0, 4};

    initial begin
        tbl[0]  = mk(8'h90, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b1);
        tbl[1]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        tbl[2]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1);
        tbl[3]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        tbl[4]  = mk(8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1);
        tbl[5]  = mk(8'h40, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1);
        tbl[6]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1);
        tbl[7]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        tbl[8]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b1);
        tbl[9]  = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        tbl[10] = mk(8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[11] = mk(8'h81, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1);
        tbl[12] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        tbl[13] = mk(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        tbl[14] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b1);
        tbl[15] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        tbl[16] = mk(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0);
        tbl[17] = mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        tbl[18] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        tbl[19] = mk(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
        tbl[20] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1);
        tbl[21] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
        tbl[22] = mk(8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1);
        tbl[23] = mk(8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        tbl[24] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1);
        tbl[25] = mk(8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

        resetn = 1'b0; req = 8'h00; mask_we = 1'b0; mask_in = 8'h00; out_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(v_f), 0);
        chk("reset_idx", int'(idx_f), 0);
        chk("reset_anyp", int'(ap_f), 0);
        resetn = 1'b1;
        step("idle0");
        step("idle1");

        // Directed vectors for the fixed-priority instance.
        for (int i = 0; i < 26; i++) begin
            req = tbl[i].req; mask_we = tbl[i].mwe; mask_in = tbl[i].min; out_ack = tbl[i].ack;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_valid", i), int'(v_f), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_anyp", i), int'(ap_f), int'(tbl[i].eap));
            if (tbl[i].ev) chk($sformatf("tbl%0d_idx", i), int'(idx_f), int'(tbl[i].eidx));
        end

        // Asynchronous reset while a grant is held.
        req = 8'h04; mask_we = 1'b0; mask_in = 8'h00; out_ack = 1'b0;
        step("prehold");
        req = 8'h00;
        chk("prehold_valid", int'(v_f), 1);
        chk("prehold_idx", int'(idx_f), 2);
        resetn = 1'b0;
        #1;
        chk("async_valid", int'(v_f), 0);
        chk("async_idx", int'(idx_f), 0);
        chk("async_anyp", int'(ap_f), 0);
        chk("async_valid_r5", int'(v_r5), 0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step("postrst0");
        step("postrst1");

        // Round-robin rotation with every line requesting and ack held high.
        req = 8'hFF; out_ack = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step("rrseq");
            if (v_r8) q8.push_back(int'(idx_r8));
            if (v_r5) begin
                chk("rr5_range", int'(idx_r5 <= 3'd4), 1);
                q5.push_back(int'(idx_r5));
            end
        end
        chk("rr8_count", q8.size(), 9);
        chk("rr5_count", int'(q5.size() >= 6), 1);
        for (int i = 0; i < 9; i++)
            if (i < q8.size()) chk($sformatf("rr8_seq%0d", i), q8[i], exp8[i]);
        for (int i = 0; i < 6; i++)
            if (i < q5.size()) chk($sformatf("rr5_seq%0d", i), q5[i], exp5[i]);

        // Randomized traffic against the model.
        resetn = 1'b0; req = 8'h00; out_ack = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            req     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            mask_we = ($urandom_range(0, 15) == 0);
            mask_in = 8'($urandom) & 8'($urandom);
            out_ack = 1'($urandom_range(0, 1));
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
